// File: rtl/logic_pair_pipe.sv
// logic_pair_pipe: paired AND / AND-OR results carried through a
// DEPTH-stage valid/ready pipeline with fused or split d semantics.
module logic_pair_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [CNT_W-1:0] xfer_cnt
);

  localparam int LAST = DEPTH - 1;

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [DEPTH-1:0] adv;
  logic [WIDTH-1:0] c_q [DEPTH];
  logic [WIDTH-1:0] c_d [DEPTH];
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [WIDTH-1:0] cprev_q;
  logic [WIDTH-1:0] cprev_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic             go;
  logic             acc;
  logic             dlv;
  logic [WIDTH-1:0] and_ab;
  logic [WIDTH-1:0] d0;

  // Advance chain, walked from the output back to stage 0; go is
  // "the stage downstream of i can take data this cycle".
  always_comb begin
    adv = '0;
    go  = out_ready;
    for (int i = LAST; i >= 0; i--) begin
      adv[i] = v_q[i] & go;
      go     = ~v_q[i] | adv[i];
    end
    in_ready = ~rst & go;
  end

  // Stage-0 results; split mode sees c_prev before this edge's update.
  always_comb begin
    acc    = in_valid & in_ready;
    dlv    = v_q[LAST] & out_ready;
    and_ab = a & b;
    d0     = mode ? (cprev_q | b) : (and_ab | b);
  end

  // Next state: load on accept or shift, drop valid on drain, else hold.
  always_comb begin
    v_d     = v_q;
    c_d     = c_q;
    d_d     = d_q;
    cprev_d = cprev_q;
    cnt_d   = cnt_q;
    if (acc) begin
      v_d[0]  = 1'b1;
      c_d[0]  = and_ab;
      d_d[0]  = d0;
      cprev_d = and_ab;
    end else if (adv[0]) begin
      v_d[0] = 1'b0;
    end
    for (int i = 1; i < DEPTH; i++) begin
      if (adv[i-1]) begin
        v_d[i] = 1'b1;
        c_d[i] = c_q[i-1];
        d_d[i] = d_q[i-1];
      end else if (adv[i]) begin
        v_d[i] = 1'b0;
      end
    end
    if (dlv) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q     <= '0;
      cprev_q <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        c_q[i] <= '0;
        d_q[i] <= '0;
      end
    end else begin
      v_q     <= v_d;
      cprev_q <= cprev_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < DEPTH; i++) begin
        c_q[i] <= c_d[i];
        d_q[i] <= d_d[i];
      end
    end
  end

  assign out_valid = v_q[LAST];
  assign c         = c_q[LAST];
  assign d         = d_q[LAST];
  assign xfer_cnt  = cnt_q;

endmodule
